// File: rtl/seg7_scan_decoder.sv
// Seven-segment scan decoder: recovers per-position digit codes
// from a multiplexed common-anode display drive.
module seg7_scan_decoder #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  DIGIT,
   input  logic [6:0]  DISPLAY,
   output logic [15:0] value,
   output logic [3:0]  valid,
   output logic [15:0] frame_value,
   output logic        frame_done,
   output logic [7:0]  frame_count,
   output logic        seg_err
);

   typedef enum logic [1:0] {
      IDLE,
      TRACK,
      HELD
   } state_t;

   localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
   localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

   state_t      state, state_nx;
   logic [10:0] cur, samp;
   logic [7:0]  cnt;
   logic [3:0]  seen;
   logic        wf;
   logic        same;
   logic        commit;
   logic [3:0]  pos_bit;
   logic [3:0]  code;
   logic        legal;
   logic        blank;
   logic [15:0] val_upd;
   logic [3:0]  seen_nx;

   assign cur     = {DIGIT, DISPLAY};
   assign same    = (cur == samp);
   assign pos_bit = ~DIGIT;

   // well-formed: exactly one anode driven low
   always_comb begin
      wf = 1'b0;
      case (DIGIT)
         4'b1110, 4'b1101,
         4'b1011, 4'b0111: wf = 1'b1;
         default:          wf = 1'b0;
      endcase
   end

   // segment pattern to digit code
   always_comb begin
      code  = 4'h0;
      legal = 1'b1;
      blank = 1'b0;
      case (DISPLAY)
         7'h40: code = 4'd0;
         7'h79: code = 4'd1;
         7'h24: code = 4'd2;
         7'h30: code = 4'd3;
         7'h19: code = 4'd4;
         7'h12: code = 4'd5;
         7'h02: code = 4'd6;
         7'h78: code = 4'd7;
         7'h00: code = 4'd8;
         7'h10: code = 4'd9;
         7'h7F: begin
            legal = 1'b0;
            blank = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

   // commit fires on the edge the counter reaches its limit
   assign commit = (state == TRACK) && wf && same
                   && (cnt == CNT_LAST);

   // next state of the capture FSM
   always_comb begin
      state_nx = state;
      if (!wf) begin
         state_nx = IDLE;
      end else if (!same) begin
         state_nx = TRACK;
      end else begin
         case (state)
            IDLE:    state_nx = TRACK;
            TRACK:   if (commit) state_nx = HELD;
            HELD:    state_nx = HELD;
            default: state_nx = IDLE;
         endcase
      end
   end

   // value with the selected nibble replaced by the new code
   always_comb begin
      val_upd = value;
      for (int i = 0; i < 4; i++) begin
         if (pos_bit[i]) val_upd[4*i +: 4] = legal ? code : 4'hF;
      end
      seen_nx = seen | pos_bit;
   end

   // sample register, stability counter and FSM state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         samp  <= '1;
         cnt   <= '0;
         state <= IDLE;
      end else begin
         samp  <= cur;
         state <= state_nx;
         if (!wf) cnt <= 8'd0;
         else if (!same) cnt <= 8'd1;
         else if (cnt < CNT_MAX) cnt <= cnt + 8'd1;
      end
   end

   // committed outputs, frame tracking and pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value       <= '0;
         valid       <= '0;
         frame_value <= '0;
         frame_done  <= 1'b0;
         frame_count <= '0;
         seg_err     <= 1'b0;
         seen        <= '0;
      end else begin
         frame_done <= 1'b0;
         seg_err    <= 1'b0;
         if (commit) begin
            if (legal || blank) begin
               value <= val_upd;
               valid <= legal ? (valid | pos_bit)
                              : (valid & DIGIT);
               if (seen_nx == 4'hF) begin
                  frame_value <= val_upd;
                  frame_done  <= 1'b1;
                  frame_count <= frame_count + 8'd1;
                  seen        <= '0;
               end else begin
                  seen <= seen_nx;
               end
            end else begin
               seg_err <= 1'b1;
            end
         end
      end
   end

endmodule
